// File: rtl/uart_pkg.sv
// Shared types, word-length encodings and parity helper for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // XOR of the data bits that belong to the configured word length.
  function automatic logic parity_calc(input logic [7:0] data, input logic [1:0] wls);
    logic [7:0] mask;
    case (wls)
      WLS_5:   mask = 8'h1F;
      WLS_6:   mask = 8'h3F;
      WLS_7:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    return ^(data & mask);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchroniser plus bit-value recovery for the UART receiver.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority vote around mid-bit).
// The consumer evaluates bit_c on the baud_tick at tick OSR/2 of a bit; the history
// flops then hold the samples taken at ticks OSR/2-1 and OSR/2-2.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic rx,
  output logic rx_s,
  output logic bit_c
);

  logic rx_m;

  // Two-flop synchroniser, resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Keep the two most recent tick samples of rx_s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 2'b11;
    end else if (baud_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  // Majority of ticks OSR/2-2, OSR/2-1 and the current tick OSR/2.
  always_comb begin
    bit_c = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
  end
`else
  logic hist;

  // Keep the sample from the previous tick (tick OSR/2-1 at decision time).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 1'b1;
    end else if (baud_tick) begin
      hist <= rx_s;
    end
  end

  // Single mid-bit sample.
  always_comb begin
    bit_c = hist;
  end
`endif

endmodule

// File: rtl/uart_rx_core.sv
// UART 16550 serial receive engine: deserialises rx, checks parity/stop/break and
// pushes one character per frame towards the RX FIFO.
// Optional build macro: UART_RX_MAJORITY_EN (majority-vote bit sampling).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned OSR = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       en,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       busy
);

  localparam int unsigned CW = $clog2(OSR);
  localparam logic [CW-1:0] MID_TICK  = CW'(OSR / 2);
  localparam logic [CW-1:0] LAST_TICK = CW'(OSR - 1);

  rx_state_t     state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data;
  logic          par_bit;
  logic          armed;
  logic          rx_s;
  logic          bit_c;
  logic          exp_par_c;
  logic          last_bit_c;

  uart_rx_sampler u_sampler (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_s      (rx_s),
    .bit_c     (bit_c)
  );

  // Expected parity bit for the character collected so far.
  always_comb begin
    exp_par_c = 1'b0;
    if (sp) begin
      exp_par_c = ~eps;
    end else if (eps) begin
      exp_par_c = parity_calc(data, wls);
    end else begin
      exp_par_c = ~parity_calc(data, wls);
    end
  end

  // Final data bit index is 4 + wls (5..8 data bits).
  always_comb begin
    last_bit_c = (bit_idx == (3'd4 + 3'(wls)));
  end

  // Receive FSM, counters and registered character outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= 3'd0;
      data     <= 8'h00;
      par_bit  <= 1'b0;
      armed    <= 1'b1;
      push     <= 1'b0;
      dout     <= 8'h00;
      pe       <= 1'b0;
      fe       <= 1'b0;
      bi       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      push <= 1'b0;
      if (!en) begin
        // Discard any partial character; only re-arm once the line is seen high.
        state    <= IDLE;
        busy     <= 1'b0;
        tick_cnt <= '0;
        armed    <= rx_s;
      end else begin
        case (state)
          IDLE: begin
            busy     <= 1'b0;
            tick_cnt <= '0;
            if (rx_s) begin
              armed <= 1'b1;
            end
            if (armed && !rx_s && baud_tick) begin
              state <= START;
              busy  <= 1'b1;
            end
          end

          START: begin
            if (baud_tick) begin
              if (tick_cnt == MID_TICK) begin
                tick_cnt <= '0;
                if (bit_c) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end else begin
                  state   <= DATA;
                  data    <= 8'h00;
                  bit_idx <= 3'd0;
                end
              end else begin
                tick_cnt <= tick_cnt + CW'(1);
              end
            end
          end

          DATA: begin
            if (baud_tick) begin
              if (tick_cnt == LAST_TICK) begin
                tick_cnt      <= '0;
                data[bit_idx] <= bit_c;
                if (last_bit_c) begin
                  state <= pen ? PARITY : STOP;
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                end
              end else begin
                tick_cnt <= tick_cnt + CW'(1);
              end
            end
          end

          PARITY: begin
            if (baud_tick) begin
              if (tick_cnt == LAST_TICK) begin
                tick_cnt <= '0;
                par_bit  <= bit_c;
                state    <= STOP;
              end else begin
                tick_cnt <= tick_cnt + CW'(1);
              end
            end
          end

          STOP: begin
            if (baud_tick) begin
              if (tick_cnt == LAST_TICK) begin
                tick_cnt <= '0;
                dout     <= data;
                pe       <= pen && (par_bit != exp_par_c);
                fe       <= ~bit_c;
                bi       <= (data == 8'h00) && (!pen || !par_bit) && !bit_c;
                push     <= 1'b1;
                armed    <= 1'b0;
                busy     <= 1'b0;
                state    <= IDLE;
              end else begin
                tick_cnt <= tick_cnt + CW'(1);
              end
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: framing, parity, false start, break, reset and disable.
module tb_uart_rx_core;

  localparam int unsigned OSR = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick = 1'b0;
  logic       en;
  logic       rx;
  logic [1:0] wls;
  logic       pen;
  logic       eps;
  logic       sp;
  logic       push;
  logic [7:0] dout;
  logic       pe;
  logic       fe;
  logic       bi;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  int base;
  logic [1:0] div = 2'd0;

  uart_rx_core #(.OSR(OSR)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .en        (en),
    .rx        (rx),
    .wls       (wls),
    .pen       (pen),
    .eps       (eps),
    .sp        (sp),
    .push      (push),
    .dout      (dout),
    .pe        (pe),
    .fe        (fe),
    .bi        (bi),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One baud tick every 4 clocks.
  always @(posedge clk) begin
    div       <= div + 2'd1;
    baud_tick <= (div == 2'd3);
  end

  // Count clock cycles with push high (one per character when push is a pulse).
  always @(negedge clk) begin
    if (push === 1'b1) push_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(OSR);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic use_par,
                            input logic par_b, input logic stop_b);
    logic [7:0] v;
    v = d;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(v[i]);
    if (use_par) send_bit(par_b);
    send_bit(stop_b);
    rx = 1'b1;
    wait_ticks(OSR);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; rx = 1'b1;
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_push", 8'(push), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_dout", dout, 8'h00);
    check("rst_pe", 8'(pe), 8'h0);
    check("rst_fe", 8'(fe), 8'h0);
    check("rst_bi", 8'(bi), 8'h0);
    rst = 1'b0;
    wait_ticks(OSR);

    // 8N1 0xA5
    base = push_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("8n1_pushes", 8'(push_cnt - base), 8'd1);
    check("8n1_dout", dout, 8'hA5);
    check("8n1_pe", 8'(pe), 8'h0);
    check("8n1_fe", 8'(fe), 8'h0);
    check("8n1_bi", 8'(bi), 8'h0);
    check("8n1_busy", 8'(busy), 8'h0);

    // 7E1 0x41 with wrong parity bit 1
    wls = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b0;
    base = push_cnt;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    check("7e1_pushes", 8'(push_cnt - base), 8'd1);
    check("7e1_dout", dout, 8'h41);
    check("7e1_pe", 8'(pe), 8'h1);
    check("7e1_fe", 8'(fe), 8'h0);

    // Stick parity, expected parity bit 1
    wls = 2'b11; pen = 1'b1; eps = 1'b0; sp = 1'b1;
    base = push_cnt;
    send_frame(8'h00, 8, 1'b1, 1'b1, 1'b1);
    check("stick1_pushes", 8'(push_cnt - base), 8'd1);
    check("stick1_dout", dout, 8'h00);
    check("stick1_pe", 8'(pe), 8'h0);
    check("stick1_bi", 8'(bi), 8'h0);
    send_frame(8'h00, 8, 1'b1, 1'b0, 1'b1);
    check("stick0_pushes", 8'(push_cnt - base), 8'd2);
    check("stick0_pe", 8'(pe), 8'h1);
    check("stick0_fe", 8'(fe), 8'h0);
    check("stick0_bi", 8'(bi), 8'h0);

    // False start: 3 ticks low
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    base = push_cnt;
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    @(negedge clk);
    check("fs_busy_hi", 8'(busy), 8'h1);
    wait_ticks(OSR);
    @(negedge clk);
    check("fs_busy_lo", 8'(busy), 8'h0);
    check("fs_pushes", 8'(push_cnt - base), 8'd0);

    // Break: line low for 3 frame times
    base = push_cnt;
    rx = 1'b0;
    wait_ticks(3 * 10 * OSR);
    @(negedge clk);
    check("brk_pushes", 8'(push_cnt - base), 8'd1);
    check("brk_dout", dout, 8'h00);
    check("brk_fe", 8'(fe), 8'h1);
    check("brk_bi", 8'(bi), 8'h1);
    check("brk_busy", 8'(busy), 8'h0);
    rx = 1'b1;
    wait_ticks(OSR);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    check("brk55_pushes", 8'(push_cnt - base), 8'd2);
    check("brk55_dout", dout, 8'h55);
    check("brk55_bi", 8'(bi), 8'h0);
    check("brk55_fe", 8'(fe), 8'h0);

    // Reset mid-DATA of 0xFF
    base = push_cnt;
    rx = 1'b0;
    wait_ticks(OSR);
    rx = 1'b1;
    wait_ticks(3 * OSR);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 8'(busy), 8'h0);
    rst = 1'b0;
    wait_ticks(6 * OSR);
    @(negedge clk);
    check("rstmid_pushes", 8'(push_cnt - base), 8'd0);
    check("rstmid_busy2", 8'(busy), 8'h0);

    // Disable mid-frame, then a 5-bit 0x1F frame
    base = push_cnt;
    rx = 1'b0;
    wait_ticks(4 * OSR);
    @(negedge clk);
    check("dis_busy_pre", 8'(busy), 8'h1);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("dis_busy", 8'(busy), 8'h0);
    wait_ticks(OSR);
    rx = 1'b1;
    en = 1'b1;
    wait_ticks(12 * OSR);
    @(negedge clk);
    check("dis_pushes", 8'(push_cnt - base), 8'd0);
    wls = 2'b00;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1);
    check("w5_pushes", 8'(push_cnt - base), 8'd1);
    check("w5_dout", dout, 8'h1F);
    check("w5_fe", 8'(fe), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive engine of the UART 16550 datapath; sits directly upstream of the RX FIFO.
- Deserialises the rx line using an oversampling baud-tick enable, checks parity, stop bit and break.
- Emits a one-cycle push with the data byte and per-character error flags, which the FIFO stores.
- Does not look at FIFO full; overrun detection belongs to the FIFO.

Parameters:
- OSR, 16, baud_tick pulses per bit period; even, 4..32; mid-bit sample point = OSR/2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- baud_tick  input  1  one-clk enable pulse, OSR per bit period
- en  input  1  receiver enable; 0 forces IDLE
- rx  input  1  asynchronous serial line, idles high
- wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- pen  input  1  parity enable
- eps  input  1  even parity select
- sp  input  1  stick parity
- push  output  1  one-clk pulse: character complete
- dout  output  8  received data, LSB-aligned, unused upper bits 0
- pe  output  1  parity error for character in dout
- fe  output  1  framing error (first stop bit sampled 0)
- bi  output  1  break indicator
- busy  output  1  high from start-bit detection to end of STOP

Behaviour:
- Reset values:
  - push, busy, pe, fe, bi = 0; dout = 8'h00.
  - rx synchroniser flops reset to 1; FSM = IDLE; armed = 1.
- Synchronisation: rx passes through a 2-flop synchroniser (rx_s) before any use.
- Counters: tick counter width $clog2(OSR), advanced only on baud_tick. Bit index counter 3 bits.
- IDLE:
  - armed set when rx_s==1.
  - When armed and rx_s==0 on a baud_tick: clear tick counter, go to START.
- START:
  - Sample at tick OSR/2-1 (mid-bit).
  - If sample==1: false start, return to IDLE; no push.
  - Otherwise clear counter, go to DATA.
- DATA:
  - Sample every OSR ticks, LSB first, 5+wls bits.
  - Then go to PARITY if pen=1, else STOP.
- PARITY: expected bit is
  - sp=1: ~eps
  - sp=0, eps=1: even parity (XOR of data bits)
  - sp=0, eps=0: ~XOR of data bits
  - pe = received != expected.
- STOP:
  - Only the first stop bit is sampled, regardless of configured stop-bit count; fe = sample==0.
  - bi = 1 when all data bits, parity (if enabled) and stop are 0.
  - Load dout/pe/fe/bi, assert push on the next clk edge after the stop sample, clear armed, return to IDLE.
- Latency and output holding:
  - push fires ~OSR/2 ticks into the stop bit; the engine does not wait for the end of the stop bit.
  - dout/pe/fe/bi hold their values until the next push.
- Re-arm rule: armed clears at every push, so a held-low line (break) yields exactly one character until rx returns high.
- Disable: en=0 at any time forces IDLE and busy=0 on the next clk; a partial character is discarded with no push.
- Reset mid-frame: all state is lost; no push is generated.
- baud_tick coinciding with the push cycle: ignored by the push logic; the tick counter still resets on entering IDLE.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value = 2-of-3 majority of rx_s at ticks OSR/2-2, OSR/2-1 and OSR/2. The START false-start check also uses the majority result.
- Undefined: single sample at tick OSR/2-1.
- Push timing is identical in both builds.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - wls encoding constants WLS_5..WLS_8
  - function parity_calc(data, wls)
- Sub-module uart_rx_sampler: 2-flop synchroniser plus optional majority vote. Outputs rx_s and the sampled bit value.

Test Plan:
- 8N1 (wls=11, pen=0), rx frame 0xA5 -> exactly one push, dout=8'hA5, pe=fe=bi=0, busy low after push.
- 7E1 (wls=10, pen=1, eps=1), data 0x41 with parity bit 1 (wrong) -> push, dout=8'h41, pe=1, fe=0.
- Stick parity (sp=1, eps=0), 8-bit 0x00 with parity bit 1 -> pe=0. Same frame with parity bit 0 -> pe=1.
- rx low for 3 ticks then high -> false start, no push, busy returns 0 by tick OSR/2.
- rx held low for 3 frame times -> one push with dout=8'h00, fe=1, bi=1. No second push until rx goes high; a following 0x55 frame -> push, dout=8'h55, bi=0.
- rst asserted mid-DATA of 0xFF -> no push, busy=0. en=0 mid-frame, then 5-bit frame 0x1F (wls=00) -> dout=8'h1F, upper bits 0.
